// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit
// Iterative RV32M multiply/divide unit in the EX stage. It watches the
// ID/EX register outputs for M-extension R-type instructions. While it
// computes, it stalls the front end. It then presents a registered result
// for one cycle (md_done) so that EX/MEM can capture it.
//
// Ports:
//   clk        pipeline clock, all state updates on posedge
//   rst        asynchronous active-low reset
//   ex_valid   EX holds a live instruction
//   ex_opcode  opcode from ID/EX
//   ex_func7   func7 from ID/EX
//   ex_func3   func3 from ID/EX, selects MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU
//   ex_op1     forwarded rs1 value
//   ex_op2     forwarded rs2 value
//   ex_wb_rd   destination register
//   flush      EX-stage kill (mispredict / trap)
//   md_stall   hold IF/ID and ID/EX while the unit is working
//   md_done    one-cycle pulse, md_result/md_rd valid
//   md_result  operation result, held until the next md_done
//   md_rd      destination register captured at start
//   md_busy    FSM not in IDLE
module ex_muldiv_unit #(
  parameter int XLEN          = 32,
  parameter bit DIV_ZERO_FAST = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  input  logic [6:0]      ex_opcode,
  input  logic [6:0]      ex_func7,
  input  logic [2:0]      ex_func3,
  input  logic [XLEN-1:0] ex_op1,
  input  logic [XLEN-1:0] ex_op2,
  input  logic [4:0]      ex_wb_rd,
  input  logic            flush,
  output logic            md_stall,
  output logic            md_done,
  output logic [XLEN-1:0] md_result,
  output logic [4:0]      md_rd,
  output logic            md_busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [32:0] mulA_q, mulA_d;
  logic [32:0] mulB_q, mulB_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dvs_q, dvs_d;
  logic [31:0] rem_q, rem_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        qNeg_q, qNeg_d;
  logic        rNeg_q, rNeg_d;
  logic [2:0]  func3_q, func3_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] result_q, result_d;

  logic        isM;
  logic        start;
  logic        divSigned;
  logic        divZero;
  logic        divOvf;
  logic        fastSpecial;
  logic [31:0] absOp1;
  logic [31:0] absOp2;
  logic [31:0] specialRes;
  logic [63:0] prod;
  logic [32:0] remShift;
  logic [32:0] trial;
  logic [31:0] quoFixed;
  logic [31:0] remFixed;

  // Instruction decode and start qualification. Start is held off while reset
  // is asserted so that the stall output stays quiet during reset.
  assign isM       = ex_valid & (ex_opcode == 7'b0110011) & (ex_func7 == 7'b0000001);
  assign start     = isM & (state_q == S_IDLE) & ~flush & rst;
  assign divSigned = ~ex_func3[0];
  assign divZero   = (ex_op2 == 32'd0);
  assign divOvf    = divSigned & (ex_op1 == 32'h8000_0000) & (ex_op2 == 32'hFFFF_FFFF);
  assign fastSpecial = DIV_ZERO_FAST & (divZero | divOvf);

  assign absOp1 = (divSigned & ex_op1[31]) ? (32'd0 - ex_op1) : ex_op1;
  assign absOp2 = (divSigned & ex_op2[31]) ? (32'd0 - ex_op2) : ex_op2;

  // Divide-by-zero gives all ones for the quotient and the dividend for the
  // remainder. Signed overflow gives the dividend back for the quotient and
  // zero for the remainder.
  always_comb begin
    specialRes = 32'd0;
    if (divZero) begin
      specialRes = ex_func3[1] ? ex_op1 : 32'hFFFF_FFFF;
    end else begin
      specialRes = ex_func3[1] ? 32'd0 : 32'h8000_0000;
    end
  end

  // The operands are already sign- or zero-extended to 33 bits, so the low 64
  // bits of their product hold every MUL/MULH* result exactly.
  assign prod = {{31{mulA_q[32]}}, mulA_q} * {{31{mulB_q[32]}}, mulB_q};

  // One restoring step. The remainder stays below the divisor, so 33 bits hold
  // the shifted value, and bit 32 of the trial difference is its borrow.
  assign remShift = {rem_q, quo_q[31]};
  assign trial    = remShift - {1'b0, dvs_q};

  assign quoFixed = qNeg_q ? (32'd0 - quo_q) : quo_q;
  assign remFixed = rNeg_q ? (32'd0 - rem_q) : rem_q;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. A flush aborts any operation in flight.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (ex_func3[2]) begin
            state_d = fastSpecial ? S_DONE : S_DIV;
          end else begin
            state_d = S_MUL;
          end
        end
      end
      S_MUL:  state_d = S_DONE;
      S_DIV:  state_d = (cnt_q == 5'd31) ? S_FIX : S_DIV;
      S_FIX:  state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
    end
  end

  // Outputs. Stall drops combinationally on flush, and it is low in DONE so
  // the pipeline advances at the end of that cycle.
  always_comb begin
    md_busy  = (state_q != S_IDLE);
    md_done  = (state_q == S_DONE) & ~flush;
    md_stall = start |
               (((state_q == S_MUL) | (state_q == S_DIV) | (state_q == S_FIX)) & ~flush);
  end

  assign md_result = result_q;
  assign md_rd     = rd_q;

  // Datapath next-state: operand capture, multiply, divide iteration, sign fix.
  always_comb begin
    mulA_d   = mulA_q;
    mulB_d   = mulB_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    qNeg_d   = qNeg_q;
    rNeg_d   = rNeg_q;
    func3_d  = func3_q;
    rd_d     = rd_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          func3_d = ex_func3;
          rd_d    = ex_wb_rd;
          if (!ex_func3[2]) begin
            // op1 is signed for MUL/MULH/MULHSU; op2 is signed for MUL/MULH.
            mulA_d = {(ex_func3[1:0] != 2'b11) & ex_op1[31], ex_op1};
            mulB_d = {~ex_func3[1] & ex_op2[31], ex_op2};
          end else begin
            quo_d  = absOp1;
            dvs_d  = absOp2;
            rem_d  = 32'd0;
            cnt_d  = 5'd0;
            qNeg_d = divSigned & (ex_op1[31] ^ ex_op2[31]) & ~divZero;
            rNeg_d = divSigned & ex_op1[31];
            if (fastSpecial) begin
              result_d = specialRes;
            end
          end
        end
      end
      S_MUL: begin
        result_d = (func3_q[1:0] == 2'b00) ? prod[31:0] : prod[63:32];
      end
      S_DIV: begin
        if (!trial[32]) begin
          rem_d = trial[31:0];
          quo_d = {quo_q[30:0], 1'b1};
        end else begin
          rem_d = remShift[31:0];
          quo_d = {quo_q[30:0], 1'b0};
        end
        cnt_d = cnt_q + 5'd1;
      end
      S_FIX: begin
        result_d = func3_q[1] ? remFixed : quoFixed;
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mulA_q   <= '0;
      mulB_q   <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      qNeg_q   <= 1'b0;
      rNeg_q   <= 1'b0;
      func3_q  <= '0;
      rd_q     <= '0;
      result_q <= '0;
    end else begin
      mulA_q   <= mulA_d;
      mulB_q   <= mulB_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
      qNeg_q   <= qNeg_d;
      rNeg_q   <= rNeg_d;
      func3_q  <= func3_d;
      rd_q     <= rd_d;
      result_q <= result_d;
    end
  end

endmodule
